// File: rtl/rf_wb_sequencer.sv
// Register-file write-port sequencer: merges ALU and buffered LSU writebacks, reports RAW hazards.
// Optional RF_WB_STALL_CNT_EN adds a saturating count of cycles where an LSU result was refused.
module rf_wb_sequencer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  input  logic                     lsu_valid,
  input  logic [AW-1:0]            lsu_rd,
  input  logic [DW-1:0]            lsu_data,
  output logic                     lsu_ready,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_wa,
  output logic [DW-1:0]            rf_wd,
  input  logic [AW-1:0]            chk_a1,
  input  logic [AW-1:0]            chk_a2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef RF_WB_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    rd_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PW-1:0]    head, tail;
  logic             alu_go, full, pop, push, push_live;

  always_comb begin
    alu_go    = alu_valid && (alu_rd != '0);
    full      = (fifo_cnt == CW'(DEPTH));
    lsu_ready = !full;
    pop       = !alu_go && (fifo_cnt != '0);
    push      = lsu_valid && !full && (lsu_rd != '0);
    push_live = !(alu_go && (lsu_rd == alu_rd));
  end

  // Control: pointers, occupancy, live bits and the write-port register
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      fifo_cnt <= '0;
      live_q   <= '0;
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
    end else begin
      // An ALU result is younger than every buffered load, so it supersedes same-rd entries.
      if (alu_go) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_q[i] == alu_rd) live_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        live_q[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (push) begin
        live_q[tail] <= push_live;
        tail         <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (alu_go) begin
        rf_we <= 1'b1;
        rf_wa <= alu_rd;
        rf_wd <= alu_data;
      end else if (pop) begin
        rf_we <= live_q[head];
        if (live_q[head]) begin
          rf_wa <= rd_q[head];
          rf_wd <= data_q[head];
        end
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail]   <= lsu_rd;
      data_q[tail] <= lsu_data;
    end
  end

  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (rd_q[i] == chk_a1)) hazard1 = 1'b1;
      if (live_q[i] && (rd_q[i] == chk_a2)) hazard2 = 1'b1;
    end
    if (rf_we && (rf_wa == chk_a1)) hazard1 = 1'b1;
    if (rf_we && (rf_wa == chk_a2)) hazard2 = 1'b1;
    if (chk_a1 == '0) hazard1 = 1'b0;
    if (chk_a2 == '0) hazard2 = 1'b0;
  end

`ifdef RF_WB_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)                      stall_cnt <= '0;
    else if (lsu_valid && full)   stall_cnt <= sat_inc(stall_cnt);
  end
`endif

endmodule
